// File: rtl/divider_seq.sv
// Sequential restoring divider: 18-bit dividend {div_hi, div_lo} / 9-bit divisor,
// one subtract-and-shift step per quotient bit, with divide-by-zero and overflow screening.
module divider_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] div_hi,
  input  logic [8:0] div_lo,
  input  logic [8:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [8:0] quotient,
  output logic [8:0] remainder,
  output logic       div_by_zero,
  output logic       overflow
);

  // Handshake: start is a request sampled only while IDLE (busy=0, done=0);
  // done is a single-cycle completion pulse and the results stay valid until the next one.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  state_t     state_next;

  logic [9:0]  r;
  logic [8:0]  q;
  logic [8:0]  m;
  logic [3:0]  cnt;

  logic [10:0] r_sh;
  logic [10:0] trial;
  logic        take;
  logic [9:0]  r_step;
  logic [8:0]  q_step;
  logic        last;
  logic        bad_zero;
  logic        bad_ovf;

  // One restoring step: borrow out of the 11-bit trial means the subtraction is rejected.
  always_comb begin
    r_sh     = {r, q[8]};
    trial    = r_sh - {2'b00, m};
    take     = ~trial[10];
    r_step   = take ? trial[9:0] : r_sh[9:0];
    q_step   = {q[7:0], take};
    last     = (cnt == 4'd8);
    bad_zero = (divisor == 9'd0);
    bad_ovf  = (div_hi >= divisor);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (bad_zero || bad_ovf) ? DONE : RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r           <= '0;
      q           <= '0;
      m           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (bad_zero) begin
              quotient    <= 9'h1FF;
              remainder   <= '0;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else if (bad_ovf) begin
              quotient    <= 9'h1FF;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
            end else begin
              r           <= {1'b0, div_hi};
              q           <= div_lo;
              m           <= divisor;
              cnt         <= '0;
              div_by_zero <= 1'b0;
              overflow    <= 1'b0;
            end
          end
        end
        RUN: begin
          r   <= r_step;
          q   <= q_step;
          cnt <= cnt + 4'd1;
          // The final step's result goes straight to the outputs on the edge entering DONE.
          if (last) begin
            quotient  <= q_step;
            remainder <= r_step[8:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Directed bench for divider_seq: hand-computed quotients/remainders, latency,
// busy width, exception paths, ignored start while running, and mid-run reset.
module tb_divider_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [8:0] div_hi;
  logic [8:0] div_lo;
  logic [8:0] divisor;
  logic       busy;
  logic       done;
  logic [8:0] quotient;
  logic [8:0] remainder;
  logic       div_by_zero;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  divider_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .div_hi      (div_hi),
    .div_lo      (div_lo),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {17'd0, busy}, 18'd0);
    check({tag, "_done"}, {17'd0, done}, 18'd0);
    check({tag, "_q"}, {9'd0, quotient}, 18'd0);
    check({tag, "_r"}, {9'd0, remainder}, 18'd0);
    check({tag, "_dz"}, {17'd0, div_by_zero}, 18'd0);
    check({tag, "_ovf"}, {17'd0, overflow}, 18'd0);
  endtask

  // Issue one start pulse, observe 20 cycles, optionally pulse start again at cycle pulse_at.
  task automatic run_op(input string tag, input logic [8:0] hi, input logic [8:0] lo,
                        input logic [8:0] dv, input int exp_lat, input int exp_busy,
                        input logic [8:0] exp_q, input logic [8:0] exp_r,
                        input logic exp_dz, input logic exp_ovf, input int pulse_at);
    int lat;
    int busy_n;
    int done_n;
    int overlap;
    logic [8:0] q_at;
    logic [8:0] r_at;
    logic dz_at;
    logic ovf_at;
    lat = 0; busy_n = 0; done_n = 0; overlap = 0;
    q_at = '0; r_at = '0; dz_at = 1'b0; ovf_at = 1'b0;
    @(negedge clk);
    div_hi = hi; div_lo = lo; divisor = dv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (busy && done) overlap++;
      if (done) begin
        done_n++;
        if (lat == 0) begin
          lat = n; q_at = quotient; r_at = remainder; dz_at = div_by_zero; ovf_at = overflow;
        end
      end
      if (n == pulse_at) begin
        div_hi = 9'd0; div_lo = 9'd9; divisor = 9'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check({tag, "_latency"}, 18'(lat), 18'(exp_lat));
    check({tag, "_busy_cycles"}, 18'(busy_n), 18'(exp_busy));
    check({tag, "_done_count"}, 18'(done_n), 18'd1);
    check({tag, "_done_busy_overlap"}, 18'(overlap), 18'd0);
    check({tag, "_quotient"}, {9'd0, q_at}, {9'd0, exp_q});
    check({tag, "_remainder"}, {9'd0, r_at}, {9'd0, exp_r});
    check({tag, "_div_by_zero"}, {17'd0, dz_at}, {17'd0, exp_dz});
    check({tag, "_overflow"}, {17'd0, ovf_at}, {17'd0, exp_ovf});
    check({tag, "_quotient_held"}, {9'd0, quotient}, {9'd0, exp_q});
    check({tag, "_remainder_held"}, {9'd0, remainder}, {9'd0, exp_r});
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0; div_hi = '0; div_lo = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op("mul_inverse", 9'd117, 9'd96,  9'd300, 10, 9, 9'd200, 9'd0, 1'b0, 1'b0, 0);
    run_op("max_product", 9'd510, 9'd1,   9'd511, 10, 9, 9'd511, 9'd0, 1'b0, 1'b0, 0);
    run_op("rem_nonzero", 9'd1,   9'd488, 9'd7,   10, 9, 9'd142, 9'd6, 1'b0, 1'b0, 0);
    run_op("rem_large",   9'd6,   9'd0,   9'd7,   10, 9, 9'd438, 9'd6, 1'b0, 1'b0, 0);
    run_op("div_by_one",  9'd0,   9'd511, 9'd1,   10, 9, 9'd511, 9'd0, 1'b0, 1'b0, 0);
    run_op("zero_dividend", 9'd0, 9'd0,   9'd1,   10, 9, 9'd0,   9'd0, 1'b0, 1'b0, 0);
    run_op("overflow",    9'd5,   9'd0,   9'd5,   1,  0, 9'h1FF, 9'd0, 1'b0, 1'b1, 0);
    run_op("div_zero",    9'd3,   9'd77,  9'd0,   1,  0, 9'h1FF, 9'd0, 1'b1, 1'b0, 0);
    run_op("start_ignored", 9'd1, 9'd488, 9'd7,   10, 9, 9'd142, 9'd6, 1'b0, 1'b0, 4);

    // Reset asserted during RUN cycle 5 aborts without a done pulse.
    done_seen = 0;
    @(negedge clk);
    div_hi = 9'd117; div_lo = 9'd96; divisor = 9'd300; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("midrun_busy_before_reset", {17'd0, busy}, 18'd1);
    rst = 1'b1;
    @(negedge clk);
    if (done) done_seen++;
    check_all_zero("midrun_reset");
    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("midrun_no_done", 18'(done_seen), 18'd0);
    check_all_zero("midrun_idle_after");

    run_op("after_reset", 9'd117, 9'd96, 9'd300, 10, 9, 9'd200, 9'd0, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
